// File: rtl/block_nest_checker.sv
// Streaming begin/end nesting checker over an ASCII character stream.
// Optional macro BLKCHK_DELIM_EXT_EN adds TAB, LF and CR as word delimiters.
module block_nest_checker #(
   parameter int CNT_W     = 32,
   parameter int MAX_DEPTH = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              in,
   input  logic                    in_valid,
   output logic signed [CNT_W-1:0] depth,
   output logic                    err_underflow,
   output logic                    err_overflow,
   output logic                    result
);

   typedef enum logic [3:0] {
      IDLE, SKIP, B1, B2, B3, B4, BN, E1, E2, ED
   } state_t;

   localparam logic signed [CNT_W-1:0] MAX_D = CNT_W'(MAX_DEPTH);
   localparam logic signed [CNT_W-1:0] ONE   = CNT_W'(1);

   function automatic logic isDelim(input logic [7:0] c);
`ifdef BLKCHK_DELIM_EXT_EN
      return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
`else
      return (c == 8'h20);
`endif
   endfunction

   function automatic logic [7:0] toLower(input logic [7:0] c);
      return ((c >= 8'h41) && (c <= 8'h5A)) ? (c | 8'h20) : c;
   endfunction

   state_t     state;
   state_t     nextOther;
   logic [7:0] lc;
   logic       dlm;

   always_comb begin
      lc        = toLower(in);
      dlm       = isDelim(in);
      nextOther = dlm ? IDLE : SKIP;
   end

   // Completed keywords bump depth immediately; a following non-delimiter undoes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         depth         <= '0;
         err_underflow <= 1'b0;
         err_overflow  <= 1'b0;
      end else if (in_valid) begin
         unique case (state)
            IDLE: begin
               if (lc == 8'h62)      state <= B1;
               else if (lc == 8'h65) state <= E1;
               else                  state <= nextOther;
            end
            SKIP: state <= nextOther;
            B1:   state <= (lc == 8'h65) ? B2 : nextOther;
            B2:   state <= (lc == 8'h67) ? B3 : nextOther;
            B3:   state <= (lc == 8'h69) ? B4 : nextOther;
            B4: begin
               if (lc == 8'h6E) begin
                  state <= BN;
                  depth <= depth + ONE;
               end else begin
                  state <= nextOther;
               end
            end
            E1:   state <= (lc == 8'h6E) ? E2 : nextOther;
            E2: begin
               if (lc == 8'h64) begin
                  state <= ED;
                  depth <= depth - ONE;
               end else begin
                  state <= nextOther;
               end
            end
            BN: begin
               if (dlm) begin
                  state <= IDLE;
                  if (depth > MAX_D) err_overflow <= 1'b1;
               end else begin
                  state <= SKIP;
                  depth <= depth - ONE;
               end
            end
            ED: begin
               if (dlm) begin
                  state <= IDLE;
                  if (depth < 0) err_underflow <= 1'b1;
               end else begin
                  state <= SKIP;
                  depth <= depth + ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign result = (depth == '0) && !err_underflow && !err_overflow;

endmodule

// File: tb/tb_block_nest_checker.sv
// Directed bench for block_nest_checker: default limit instance plus a MAX_DEPTH=2 instance.
module tb_block_nest_checker;

   logic              clk;
   logic              reset;
   logic [7:0]        in;
   logic              in_valid;
   logic signed [31:0] depthA, depthB;
   logic              uflA, oflA, resA;
   logic              uflB, oflB, resB;

   int testsRun;
   int testsFailed;

   block_nest_checker #(.CNT_W(32), .MAX_DEPTH(255)) dutA (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .depth(depthA), .err_underflow(uflA), .err_overflow(oflA), .result(resA)
   );

   block_nest_checker #(.CNT_W(32), .MAX_DEPTH(2)) dutB (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .depth(depthB), .err_underflow(uflB), .err_overflow(oflB), .result(resB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic doReset();
      in_valid = 1'b0;
      in       = 8'h00;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic sendStr(input string s);
      for (int i = 0; i < s.len(); i++) begin
         in       = s[i];
         in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      in          = 8'h00;
      in_valid    = 1'b0;
      reset       = 1'b0;

      // 1: basic begin/end
      doReset();
      checkVal("rst_depth", depthA, 0);
      checkVal("rst_ufl", {31'd0, uflA}, 0);
      checkVal("rst_ofl", {31'd0, oflA}, 0);
      checkVal("rst_result", {31'd0, resA}, 1);
      sendStr("begin");
      checkVal("t1_depth_n", depthA, 1);
      checkVal("t1_result_n", {31'd0, resA}, 0);
      sendStr(" end ");
      checkVal("t1_depth_end", depthA, 0);
      checkVal("t1_result_end", {31'd0, resA}, 1);
      checkVal("t1_ufl", {31'd0, uflA}, 0);
      checkVal("t1_ofl", {31'd0, oflA}, 0);

      // 2: undo on longer word, then underflow
      doReset();
      sendStr("beginx");
      checkVal("t2_depth_x", depthA, 0);
      sendStr(" end");
      checkVal("t2_depth_d", depthA, -1);
      checkVal("t2_result_d", {31'd0, resA}, 0);
      checkVal("t2_ufl_pre", {31'd0, uflA}, 0);
      sendStr(" ");
      checkVal("t2_ufl", {31'd0, uflA}, 1);
      sendStr("begin ");
      checkVal("t2_depth_final", depthA, 0);
      checkVal("t2_result_final", {31'd0, resA}, 0);

      // 3: no trailing delimiter
      doReset();
      sendStr("end");
      checkVal("t3_depth", depthA, -1);
      checkVal("t3_ufl", {31'd0, uflA}, 0);
      checkVal("t3_result", {31'd0, resA}, 0);

      // 4: overflow with MAX_DEPTH=2
      doReset();
      sendStr("begin begin begin");
      checkVal("t4_ofl_pre", {31'd0, oflB}, 0);
      sendStr(" ");
      checkVal("t4_ofl", {31'd0, oflB}, 1);
      checkVal("t4_depth", depthB, 3);
      checkVal("t4_ofl_big", {31'd0, oflA}, 0);
      sendStr("end end end ");
      checkVal("t4_depth_final", depthB, 0);
      checkVal("t4_result_final", {31'd0, resB}, 0);
      checkVal("t4_result_big", {31'd0, resA}, 1);

      // 5: mixed case and in_valid gaps
      doReset();
      sendStr("BeGiN");
      checkVal("t5_depth_n", depthA, 1);
      in = "x";
      in_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
         @(posedge clk);
         #1;
         checkVal("t5_gap_depth", depthA, 1);
      end
      sendStr(" EnD ");
      checkVal("t5_depth_final", depthA, 0);
      checkVal("t5_result_final", {31'd0, resA}, 1);

      // 6: async reset mid-word
      doReset();
      sendStr("end begi");
      checkVal("t6_depth_pre", depthA, -1);
      checkVal("t6_ufl_pre", {31'd0, uflA}, 1);
      #2;
      reset = 1'b1;
      #1;
      checkVal("t6_async_depth", depthA, 0);
      checkVal("t6_async_ufl", {31'd0, uflA}, 0);
      checkVal("t6_async_result", {31'd0, resA}, 1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      sendStr("n ");
      checkVal("t6_depth_after", depthA, 0);
      checkVal("t6_result_after", {31'd0, resA}, 1);

      // 7: whitespace variants
      doReset();
      sendStr("begin\tend\n");
      checkVal("t7_depth", depthA, 0);
      checkVal("t7_result", {31'd0, resA}, 1);
      checkVal("t7_ufl", {31'd0, uflA}, 0);
      checkVal("t7_ofl", {31'd0, oflA}, 0);
      doReset();
      sendStr("\tend ");
`ifdef BLKCHK_DELIM_EXT_EN
      checkVal("t7_tab_depth", depthA, -1);
      checkVal("t7_tab_ufl", {31'd0, uflA}, 1);
`else
      checkVal("t7_tab_depth", depthA, 0);
      checkVal("t7_tab_ufl", {31'd0, uflA}, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
